// File: rtl/pe_pkg.sv
// pe_pkg: shared widths and arithmetic helpers for the double-buffered systolic PE.
// Helpers work on a fixed 64-bit operand so any instance width up to 63 bits fits.
package pe_pkg;

    localparam int X_W_D   = 9;
    localparam int W_W_D   = 9;
    localparam int MAC_W_D = 32;
    localparam int OP_W    = 64;
    localparam int IDX_W   = $clog2(OP_W);

    function automatic logic [OP_W-1:0] ext_op(input logic [OP_W-1:0] v, input int w, input logic sgn);
        logic [OP_W-1:0] m;
        m = {OP_W{1'b1}} << w;
        return (sgn && v[IDX_W'(w - 1)]) ? (v | m) : (v & ~m);
    endfunction

    function automatic logic [OP_W-1:0] ext_mul(input logic [OP_W-1:0] x, input logic [OP_W-1:0] w,
                                                input int xw, input int ww, input logic sgn);
        return ext_op(x, xw, sgn) * ext_op(w, ww, sgn);
    endfunction

    // Returns {sat_flag, sum}; the flag is raised only when the clamp changes the value.
    function automatic logic [OP_W:0] sat_add(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                              input int macw, input logic sgn, input logic sat_en);
        logic signed [OP_W-1:0] s;
        logic signed [OP_W-1:0] hi;
        logic signed [OP_W-1:0] lo;
        s  = signed'(a + b);
        hi = signed'((OP_W'(1) << (sgn ? macw - 1 : macw)) - OP_W'(1));
        lo = sgn ? -signed'(OP_W'(1) << (macw - 1)) : '0;
        if (sat_en && s > hi)
            return {1'b1, hi};
        if (sat_en && s < lo)
            return {1'b1, lo};
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/pe_dbuf_sat_wbuf.sv
// pe_wbuf: shadow/active weight pair; a swap promotes the pre-write shadow value.
// The effective weight already reflects a swap issued in the same cycle.
module pe_wbuf
    import pe_pkg::*;
#(
    parameter int W_W = W_W_D
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [W_W-1:0] w_i,
    input  logic           w_wr_i,
    input  logic           swap_i,
    output logic [W_W-1:0] w_eff_o,
    output logic [W_W-1:0] w_act_o
);

    logic [W_W-1:0] shadow_q;
    logic [W_W-1:0] act_q;

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            shadow_q <= '0;
            act_q    <= '0;
        end else begin
            if (w_wr_i)
                shadow_q <= w_i;
            if (swap_i)
                act_q <= shadow_q;
        end

    assign w_eff_o = swap_i ? shadow_q : act_q;
    assign w_act_o = act_q;

endmodule

// File: rtl/pe_dbuf_sat.sv
// pe_dbuf_sat: weight-stationary MAC PE with double-buffered weight, swap token, saturation and sticky flags.
// Optional product register (PIPE) adds one cycle to the mac path only; x path is always one cycle.
module pe_dbuf_sat
    import pe_pkg::*;
#(
    parameter int X_W    = X_W_D,
    parameter int W_W    = W_W_D,
    parameter int MAC_W  = MAC_W_D,
    parameter int SAT_EN = 1,
    parameter int PIPE   = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sign_i,
    input  logic [X_W-1:0]   x_i,
    input  logic             x_v_i,
    input  logic             x_swap_i,
    input  logic [MAC_W-1:0] mac_i,
    input  logic             mac_v_i,
    input  logic [W_W-1:0]   w_i,
    input  logic             w_wr_i,
    input  logic             clr_i,
    output logic [X_W-1:0]   x_o,
    output logic             x_v_o,
    output logic             x_swap_o,
    output logic [MAC_W-1:0] mac_o,
    output logic             mac_v_o,
    output logic [W_W-1:0]   w_act_o,
    output logic             sat_o,
    output logic             err_o
);

    localparam int P_W = X_W + W_W;

    logic                  swap;
    logic                  beat;
    logic                  err_set;
    logic                  sat_set;
    logic                  sat_c;
    logic                  op_v;
    logic [W_W-1:0]        w_eff;
    logic [P_W-1:0]        prod_c;
    logic [P_W-1:0]        op_p;
    logic [MAC_W-1:0]      op_m;
    logic [MAC_W-1:0]      sum_c;
    logic [OP_W-P_W-1:0]   prod_unused;
    logic [OP_W-MAC_W-1:0] sum_unused;

    assign swap    = x_v_i && x_swap_i;
    assign beat    = x_v_i && mac_v_i;
    assign err_set = mac_v_i && !x_v_i;

    pe_wbuf #(.W_W(W_W)) u_wbuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .w_i     (w_i),
        .w_wr_i  (w_wr_i),
        .swap_i  (swap),
        .w_eff_o (w_eff),
        .w_act_o (w_act_o)
    );

    assign {prod_unused, prod_c} = ext_mul(OP_W'(x_i), OP_W'(w_eff), X_W, W_W, sign_i);

    generate
        if (PIPE != 0) begin : g_pipe
            logic [P_W-1:0]   p_q;
            logic [MAC_W-1:0] m_q;
            logic             v_q;
            always_ff @(posedge clk_i or negedge rst_i)
                if (!rst_i) begin
                    p_q <= '0;
                    m_q <= '0;
                    v_q <= 1'b0;
                end else begin
                    v_q <= beat;
                    if (beat) begin
                        p_q <= prod_c;
                        m_q <= mac_i;
                    end
                end
            assign op_p = p_q;
            assign op_m = m_q;
            assign op_v = v_q;
        end else begin : g_comb
            assign op_p = prod_c;
            assign op_m = mac_i;
            assign op_v = beat;
        end
    endgenerate

    // Product is re-extended from P_W bits, which always holds the exact product.
    assign {sat_c, sum_unused, sum_c} = sat_add(ext_op(OP_W'(op_p), P_W, sign_i),
                                                ext_op(OP_W'(op_m), MAC_W, sign_i),
                                                MAC_W, sign_i, SAT_EN != 0);
    assign sat_set = op_v && sat_c;

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            x_o      <= '0;
            x_v_o    <= 1'b0;
            x_swap_o <= 1'b0;
            mac_o    <= '0;
            mac_v_o  <= 1'b0;
            sat_o    <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            x_v_o    <= x_v_i;
            x_swap_o <= swap;
            if (x_v_i)
                x_o <= x_i;
            mac_v_o <= op_v;
            if (op_v)
                mac_o <= sum_c;
            sat_o <= sat_set || (sat_o && !clr_i);
            err_o <= err_set || (err_o && !clr_i);
        end

endmodule
